// File: rtl/pwm_breath_ctrl.sv
// Breathing-LED duty sequencer: ramps the PWM duty up, holds, ramps down, holds, then finishes.
// Build option BREATH_AUTO_REPEAT_EN: after HOLD_LO, restart the ramp instead of returning to IDLE.
module pwm_breath_ctrl #(
  parameter int unsigned STEP_TICKS = 4,
  parameter int unsigned DUTY_STEP  = 8,
  parameter int unsigned HOLD_TICKS = 64,
  parameter int unsigned DUTY_MAX   = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       period_tick_i,
  output logic [7:0] duty_o,
  output logic       busy_o,
  output logic [2:0] phase_o,
  output logic       done_o
);

  // state       | meaning
  // S_IDLE      | waiting for start, duty held at 0
  // S_RAMP_UP   | duty rises by DUTY_STEP every STEP_TICKS ticks, saturating at DUTY_MAX
  // S_HOLD_HI   | duty held at DUTY_MAX for HOLD_TICKS ticks
  // S_RAMP_DOWN | duty falls by DUTY_STEP every STEP_TICKS ticks, saturating at 0
  // S_HOLD_LO   | duty held at 0 for HOLD_TICKS ticks, then done
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_HOLD_HI   = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_HOLD_LO   = 3'd4
  } state_t;

  localparam logic [7:0]  STEP_LAST  = 8'(STEP_TICKS - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_TICKS - 1);
  localparam logic [8:0]  DUTY_STEP9 = 9'(DUTY_STEP);
  localparam logic [8:0]  DUTY_MAX9  = 9'(DUTY_MAX);
  localparam logic [7:0]  DUTY_STEP8 = 8'(DUTY_STEP);
  localparam logic [7:0]  DUTY_MAX8  = 8'(DUTY_MAX);

  state_t      state_q, state_d;
  logic [7:0]  duty_q, duty_d;
  logic [7:0]  step_cnt_q, step_cnt_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [8:0]  up_sum;
  logic [7:0]  up_duty;
  logic [7:0]  down_duty;
  logic        step_hit;
  logic        hold_hit;

  // 9-bit sum so a step past 255 saturates instead of wrapping
  always_comb begin
    up_sum    = {1'b0, duty_q} + DUTY_STEP9;
    up_duty   = (up_sum >= DUTY_MAX9) ? DUTY_MAX8 : up_sum[7:0];
    down_duty = (duty_q <= DUTY_STEP8) ? 8'd0 : (duty_q - DUTY_STEP8);
    step_hit  = period_tick_i && (step_cnt_q == STEP_LAST);
    hold_hit  = period_tick_i && (hold_cnt_q == HOLD_LAST);
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    done_d     = 1'b0;

    if (stop_i) begin
      state_d    = S_IDLE;
      duty_d     = 8'd0;
      step_cnt_d = 8'd0;
      hold_cnt_d = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_d    = S_RAMP_UP;
            duty_d     = 8'd0;
            step_cnt_d = 8'd0;
            hold_cnt_d = 16'd0;
          end
        end

        S_RAMP_UP: begin
          if (step_hit) begin
            step_cnt_d = 8'd0;
            duty_d     = up_duty;
            if (up_duty == DUTY_MAX8) begin
              state_d    = S_HOLD_HI;
              hold_cnt_d = 16'd0;
            end
          end else if (period_tick_i) begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end

        S_HOLD_HI: begin
          if (hold_hit) begin
            state_d    = S_RAMP_DOWN;
            step_cnt_d = 8'd0;
            hold_cnt_d = 16'd0;
          end else if (period_tick_i) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end

        S_RAMP_DOWN: begin
          if (step_hit) begin
            step_cnt_d = 8'd0;
            duty_d     = down_duty;
            if (down_duty == 8'd0) begin
              state_d    = S_HOLD_LO;
              hold_cnt_d = 16'd0;
            end
          end else if (period_tick_i) begin
            step_cnt_d = step_cnt_q + 8'd1;
          end
        end

        S_HOLD_LO: begin
          if (hold_hit) begin
            done_d     = 1'b1;
            duty_d     = 8'd0;
            step_cnt_d = 8'd0;
            hold_cnt_d = 16'd0;
`ifdef BREATH_AUTO_REPEAT_EN
            state_d    = S_RAMP_UP;
`else
            state_d    = S_IDLE;
`endif
          end else if (period_tick_i) begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
        end

        default: begin
          state_d    = S_IDLE;
          duty_d     = 8'd0;
          step_cnt_d = 8'd0;
          hold_cnt_d = 16'd0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      duty_q     <= 8'd0;
      step_cnt_q <= 8'd0;
      hold_cnt_q <= 16'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign duty_o  = duty_q;
  assign busy_o  = busy_q;
  assign phase_o = state_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for pwm_breath_ctrl: full breath cycle, abort, async reset and sparse-tick gating.
// Honors BREATH_AUTO_REPEAT_EN for the expected state after HOLD_LO.
module tb_pwm_breath_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, tick;
  logic [7:0] duty;
  logic       busy, done;
  logic [2:0] phase;

  logic       g_start, g_stop, g_tick;
  logic [7:0] g_duty;
  logic       g_busy, g_done;
  logic [2:0] g_phase;

  int total = 0;
  int bad   = 0;
  int exp_d;
  int prev_d;

`ifdef BREATH_AUTO_REPEAT_EN
  localparam int END_PHASE = 1;
  localparam int END_BUSY  = 1;
`else
  localparam int END_PHASE = 0;
  localparam int END_BUSY  = 0;
`endif

  always #5 clk = ~clk;

  pwm_breath_ctrl u_dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .stop_i        (stop),
    .period_tick_i (tick),
    .duty_o        (duty),
    .busy_o        (busy),
    .phase_o       (phase),
    .done_o        (done)
  );

  pwm_breath_ctrl #(
    .STEP_TICKS (1),
    .DUTY_STEP  (255),
    .HOLD_TICKS (64),
    .DUTY_MAX   (255)
  ) u_gate (
    .clk           (clk),
    .rst           (rst),
    .start_i       (g_start),
    .stop_i        (g_stop),
    .period_tick_i (g_tick),
    .duty_o        (g_duty),
    .busy_o        (g_busy),
    .phase_o       (g_phase),
    .done_o        (g_done)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b1;
    g_start = 1'b0; g_stop = 1'b0; g_tick = 1'b0;
    cyc(2);
    check_val("rst_duty", duty, 0);
    check_val("rst_phase", phase, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    rst = 1'b0;
    cyc(5);
    check_val("idle_stays_phase", phase, 0);
    check_val("idle_stays_duty", duty, 0);

    // full ramp-up
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check_val("up_enter_phase", phase, 1);
    check_val("up_enter_busy", busy, 1);
    check_val("up_enter_duty", duty, 0);
    prev_d = 0;
    for (int k = 1; k <= 32; k++) begin
      exp_d = (8 * k > 255) ? 255 : 8 * k;
      cyc(3);
      check_val("up_between", duty, prev_d);
      cyc(1);
      check_val("up_step", duty, exp_d);
      check_val("up_phase", phase, (k == 32) ? 2 : 1);
      prev_d = exp_d;
    end

    // HOLD_HI lasts 64 ticks
    cyc(63);
    check_val("hold_hi_phase", phase, 2);
    check_val("hold_hi_duty", duty, 255);
    cyc(1);
    check_val("down_enter_phase", phase, 3);

    prev_d = 255;
    for (int k = 1; k <= 32; k++) begin
      exp_d = (255 - 8 * k < 0) ? 0 : 255 - 8 * k;
      cyc(3);
      check_val("down_between", duty, prev_d);
      cyc(1);
      check_val("down_step", duty, exp_d);
      check_val("down_phase", phase, (k == 32) ? 4 : 3);
      prev_d = exp_d;
    end

    cyc(63);
    check_val("hold_lo_phase", phase, 4);
    check_val("hold_lo_done", done, 0);
    cyc(1);
    check_val("done_pulse", done, 1);
    check_val("end_phase", phase, END_PHASE);
    check_val("end_busy", busy, END_BUSY);
    check_val("end_duty", duty, 0);
    cyc(1);
    check_val("done_one_cycle", done, 0);

    // abort at duty 120 in RAMP_UP
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check_val("pre_abort_idle", phase, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(60);
    check_val("abort_at_120", duty, 120);
    check_val("abort_at_phase", phase, 1);
    stop = 1'b1;
    start = 1'b1;
    cyc(1);
    check_val("abort_phase", phase, 0);
    check_val("abort_duty", duty, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    cyc(1);
    stop = 1'b0;
    start = 1'b0;
    check_val("start_stop_idle_phase", phase, 0);
    check_val("start_stop_idle_busy", busy, 0);
    cyc(3);
    check_val("after_abort_idle", phase, 0);

    // async reset in HOLD_HI, then replay
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(128 + 10);
    check_val("pre_rst_phase", phase, 2);
    check_val("pre_rst_duty", duty, 255);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_duty", duty, 0);
    check_val("async_rst_phase", phase, 0);
    check_val("async_rst_busy", busy, 0);
    #1;
    rst = 1'b0;
    cyc(3);
    check_val("post_rst_idle", phase, 0);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check_val("replay_enter", duty, 0);
    check_val("replay_phase", phase, 1);
    cyc(4);
    check_val("replay_step1", duty, 8);
    cyc(4);
    check_val("replay_step2", duty, 16);

    // sparse ticks on the single-step instance
    tick = 1'b0;
    stop = 1'b1;
    check_val("gate_idle", g_phase, 0);
    g_start = 1'b1;
    cyc(1);
    g_start = 1'b0;
    stop = 1'b0;
    check_val("gate_enter_phase", g_phase, 1);
    check_val("gate_enter_duty", g_duty, 0);
    cyc(100);
    check_val("gate_no_tick_duty", g_duty, 0);
    check_val("gate_no_tick_phase", g_phase, 1);
    g_start = 1'b1;
    cyc(1);
    g_start = 1'b0;
    check_val("gate_busy_start_phase", g_phase, 1);
    check_val("gate_busy_start_duty", g_duty, 0);
    cyc(153);
    g_tick = 1'b1;
    cyc(1);
    g_tick = 1'b0;
    check_val("gate_tick_duty", g_duty, 255);
    check_val("gate_tick_phase", g_phase, 2);
    g_start = 1'b1;
    cyc(1);
    g_start = 1'b0;
    cyc(254);
    check_val("gate_hold_duty", g_duty, 255);
    check_val("gate_hold_phase", g_phase, 2);
    g_tick = 1'b1;
    cyc(1);
    g_tick = 1'b0;
    check_val("gate_hold_tick2", g_phase, 2);
    check_val("gate_hold_done", g_done, 0);
    check_val("gate_busy", g_busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_breath_ctrl.md
PWM_BREATH_CTRL -- requirements
Module: pwm_breath_ctrl

Interface
REQ-001 Parameter STEP_TICKS, default 4, is the number of period_tick pulses per duty step (legal 1..255).
REQ-002 Parameter DUTY_STEP, default 8, is the duty increment/decrement per step (legal 1..255).
REQ-003 Parameter HOLD_TICKS, default 64, is the number of period_tick pulses spent in each hold state (legal 1..65535).
REQ-004 Parameter DUTY_MAX, default 255, is the ramp ceiling (legal 1..255).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 start  input  1  one-cycle request to begin a breath sequence.
REQ-008 stop  input  1  one-cycle request to abort to IDLE.
REQ-009 period_tick  input  1  one-cycle pulse from the PWM counter wrap (count 255 to 0).
REQ-010 duty  output  8  registered duty value driven to the PWM compare input and the 7-segment display value.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 phase  output  3  state code: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DOWN=3, HOLD_LO=4.
REQ-013 done  output  1  one-cycle pulse on completion of HOLD_LO.

Function
REQ-014 In IDLE, start=1 and stop=0 SHALL move the FSM to RAMP_UP on the next edge, with duty=0 and the tick and hold counters cleared.
REQ-015 start SHALL be ignored in every non-IDLE state.
REQ-016 stop=1 in any state SHALL force IDLE on the next edge, with duty=0 and counters cleared; done SHALL stay 0; stop SHALL win over a simultaneous start, period_tick or step.
REQ-017 period_tick SHALL be counted only in non-IDLE states; no other input advances the counters.
REQ-018 In the ramp states, the step counter SHALL increment on each period_tick; on the period_tick where it equals STEP_TICKS-1, it SHALL clear and duty SHALL step on that same edge.
REQ-019 RAMP_UP step: duty = min(duty+DUTY_STEP, DUTY_MAX), computed 9 bits wide with no wrap; when the new duty equals DUTY_MAX, the FSM SHALL enter HOLD_HI on that same edge.
REQ-020 RAMP_DOWN step: duty = max(duty-DUTY_STEP, 0), computed without underflow; when the new duty equals 0, the FSM SHALL enter HOLD_LO on that same edge.
REQ-021 HOLD_HI and HOLD_LO SHALL keep duty constant and count HOLD_TICKS period_ticks; on the HOLD_TICKS-th tick the FSM SHALL advance (HOLD_HI to RAMP_DOWN; HOLD_LO per REQ-027/028).
REQ-022 Every state transition SHALL clear the step and hold counters.
REQ-023 duty, phase and busy SHALL be registered; a change SHALL be visible the cycle after the causing edge condition, with no combinational input-to-output path.

Reset
REQ-024 Asserting rst SHALL immediately force IDLE, duty=0, busy=0, phase=0, done=0 and all counters to 0, including mid-ramp.
REQ-025 After rst deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-026 Macro BREATH_AUTO_REPEAT_EN selects the behaviour at HOLD_LO completion.
REQ-027 With BREATH_AUTO_REPEAT_EN defined, HOLD_LO completion SHALL pulse done and enter RAMP_UP, cycling until stop or rst.
REQ-028 Without BREATH_AUTO_REPEAT_EN, HOLD_LO completion SHALL pulse done and enter IDLE (busy=0 on the next cycle).

Verification
REQ-029 Bench SHALL cover the following; default parameters unless stated, with period_tick held high every cycle.
- Full ramp-up: start -> duty sequence 0, 8, ..., 248, 255, each step 4 cycles apart; HOLD_HI entered after 32 steps (128 ticks).
- Ramp-down and done: after 64 HOLD_HI ticks -> duty 247, 239, ..., 7, 0 (32 steps); HOLD_LO for 64 ticks; done=1 for exactly 1 cycle; phase=0 without the macro, phase=1 with it.
- Abort: stop at duty=120 in RAMP_UP -> next cycle phase=0, duty=0, busy=0, done=0; start together with stop in IDLE -> stays IDLE.
- Reset mid-operation: rst asserted asynchronously in HOLD_HI -> duty=0, phase=0 before the next clk edge; a fresh start then replays ramp-up from 0.
- Tick gating: period_tick every 256 cycles, STEP_TICKS=1, DUTY_STEP=255 -> duty 0 to 255 on the first tick, HOLD_HI; extra start pulses while busy have no effect.
